// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared types and constants for the reaction-timer stimulus controller
//
// Purpose: state encoding, LFSR seed/taps and the display-range limit.
// Ports:   none (package).
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    STIM  = 3'd2,
    DONE  = 3'd3,
    EARLY = 3'd4
  } rt_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as a mask over q[15:0].
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  // Largest value the 4-digit display path can show.
  localparam int          RT_MAX    = 9999;

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Fibonacci LFSR for the random stimulus delay
//
// Purpose: advances every clock; the delay logic samples low bits of q.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset, loads LFSR_SEED
//   q     - current LFSR contents
module lfsr16
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  logic fb;

  assign fb = ^(q & LFSR_TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LFSR_SEED;
    end else if (q == 16'h0000) begin
      // Lock-up state is unreachable from the seed; recover anyway if upset.
      q <= LFSR_SEED;
    end else begin
      q <= {q[14:0], fb};
    end
  end

endmodule

// File: rtl/reaction_stimulus_ctrl.sv
// rtl/reaction_stimulus_ctrl.sv - arm/random-wait/stimulus/measure controller for the reaction timer
//
// Purpose: waits a pseudo-random delay after start, lights the stimulus,
//          counts reaction time in ms until stop, flags early press/timeout.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   clear, start, stop  - single-cycle debounced pulses (priority clear>stop>start)
//   stim_led, time_en   - high in STIM
//   ms_tick             - 1 ms pulse while in WAIT or STIM
//   rt_ms, rt_valid     - reaction time (binary ms) and its one-cycle valid pulse
//   early, timeout      - early-press level, timeout level (in DONE)
//   state_o             - state encoding for debug LEDs
module reaction_stimulus_ctrl
  import reaction_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int MIN_DELAY_MS = 2000,
  parameter int RAND_BITS    = 11,
  parameter int TIMEOUT_MS   = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        start,
  input  logic        stop,
  output logic        stim_led,
  output logic        time_en,
  output logic        ms_tick,
  output logic [13:0] rt_ms,
  output logic        rt_valid,
  output logic        early,
  output logic        timeout,
  output logic [2:0]  state_o
);

  localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW     = $clog2(MIN_DELAY_MS + (1 << RAND_BITS)) + 1;
  localparam int TO     = (TIMEOUT_MS > RT_MAX) ? RT_MAX : TIMEOUT_MS;

  rt_state_t     state;
  logic [PW-1:0] presc;
  logic [DW-1:0] delay_cnt;
  logic [15:0]   lfsr_q;
  logic          tick;
  logic          unused_lfsr_bits;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  // Only the low RAND_BITS feed the delay.
  assign unused_lfsr_bits = ^lfsr_q;

  // Prescaler is held at 0 outside WAIT/STIM, so tick is purely a register decode.
  assign tick     = (presc == PW'(TICK_DIV - 1)) && ((state == WAIT) || (state == STIM));
  assign ms_tick  = tick;
  assign stim_led = (state == STIM);
  assign time_en  = (state == STIM);
  assign early    = (state == EARLY);
  assign state_o  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      presc     <= '0;
      delay_cnt <= '0;
      rt_ms     <= '0;
      rt_valid  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      rt_valid <= 1'b0;
      if (clear) begin
        state   <= IDLE;
        presc   <= '0;
        rt_ms   <= '0;
        timeout <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            presc <= '0;
            if (start) begin
              delay_cnt <= DW'(MIN_DELAY_MS) + DW'(lfsr_q[RAND_BITS-1:0]);
              rt_ms     <= '0;
              timeout   <= 1'b0;
              state     <= WAIT;
            end
          end
          WAIT: begin
            if (stop) begin
              state <= EARLY;
              presc <= '0;
              rt_ms <= '0;
            end else if (tick) begin
              // Wrap to 0 here also gives STIM a full-length first ms.
              presc     <= '0;
              delay_cnt <= delay_cnt - 1'b1;
              if (delay_cnt == DW'(1)) begin
                state <= STIM;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          STIM: begin
            if (stop) begin
              // A tick in the same cycle is deliberately dropped.
              state    <= DONE;
              presc    <= '0;
              rt_valid <= 1'b1;
            end else if (tick) begin
              presc <= '0;
              if (rt_ms == 14'(TO - 1)) begin
                rt_ms    <= 14'(TO);
                timeout  <= 1'b1;
                rt_valid <= 1'b1;
                state    <= DONE;
              end else begin
                rt_ms <= rt_ms + 1'b1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          DONE: begin
            presc <= '0;
          end
          EARLY: begin
            presc <= '0;
            rt_ms <= '0;
          end
          default: begin
            state <= IDLE;
            presc <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reaction_stimulus_ctrl.sv
// tb/tb_reaction_stimulus_ctrl.sv - directed self-checking bench for reaction_stimulus_ctrl
module tb_reaction_stimulus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        start;
  logic        stop;
  logic        stim_led;
  logic        time_en;
  logic        ms_tick;
  logic [13:0] rt_ms;
  logic        rt_valid;
  logic        early;
  logic        timeout;
  logic [2:0]  state_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_delay;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  reaction_stimulus_ctrl #(
    .TICK_DIV     (4),
    .MIN_DELAY_MS (3),
    .RAND_BITS    (2),
    .TIMEOUT_MS   (10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .start    (start),
    .stop     (stop),
    .stim_led (stim_led),
    .time_en  (time_en),
    .ms_tick  (ms_tick),
    .rt_ms    (rt_ms),
    .rt_valid (rt_valid),
    .early    (early),
    .timeout  (timeout),
    .state_o  (state_o)
  );

  // Reference LFSR: taps 16,14,13,11 written out bit by bit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Called at a negedge; pulses start and returns at the negedge where stim_led is first seen.
  task automatic start_trial(input string tag, output int n, output int ticks);
    start     = 1'b1;
    exp_delay = 3 + int'(m_lfsr[1:0]);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_wait_state"}, 32'(state_o), 32'd1);
    n     = 0;
    ticks = 0;
    while (!stim_led && n < 200) begin
      if (ms_tick) ticks++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_ticks(input int k);
    int c = 0;
    int g = 0;
    while (c < k && g < 500) begin
      @(negedge clk);
      g++;
      if (ms_tick) c++;
    end
    if (c < k) chk("tick_wait_bound", 32'(c), 32'(k));
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    int n;
    int t;
    int bad;
    rst_n = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_state",    32'(state_o),  32'd0);
    chk("rst_stim_led", 32'(stim_led), 32'd0);
    chk("rst_time_en",  32'(time_en),  32'd0);
    chk("rst_ms_tick",  32'(ms_tick),  32'd0);
    chk("rst_rt_ms",    32'(rt_ms),    32'd0);
    chk("rst_rt_valid", 32'(rt_valid), 32'd0);
    chk("rst_early",    32'(early),    32'd0);
    chk("rst_timeout",  32'(timeout),  32'd0);

    // Trial 1: ACE1 -> delay 4 ms -> 16 cycles; then stop after 6 ticks.
    rst_n = 1'b1;
    start_trial("t1", n, t);
    chk("t1_wait_cycles", 32'(n), 32'd16);
    chk("t1_wait_ticks",  32'(t), 32'd4);
    chk("t1_state_stim",  32'(state_o), 32'd2);
    chk("t1_time_en",     32'(time_en), 32'd1);
    wait_ticks(6);
    @(negedge clk);
    chk("t1_rt_before_stop", 32'(rt_ms), 32'd6);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t1_done_state", 32'(state_o),  32'd3);
    chk("t1_rt_ms",      32'(rt_ms),    32'd6);
    chk("t1_rt_valid",   32'(rt_valid), 32'd1);
    chk("t1_timeout",    32'(timeout),  32'd0);
    chk("t1_stim_off",   32'(stim_led), 32'd0);
    chk("t1_time_en_off",32'(time_en),  32'd0);
    @(negedge clk);
    chk("t1_rt_valid_once", 32'(rt_valid), 32'd0);
    chk("t1_rt_hold",       32'(rt_ms),    32'd6);

    // Trial 2: no stop -> timeout at 10 ms.
    pulse_clear();
    chk("clr_state", 32'(state_o), 32'd0);
    chk("clr_rt_ms", 32'(rt_ms),   32'd0);
    start_trial("t2", n, t);
    chk("t2_wait_cycles", 32'(n), 32'(exp_delay * 4));
    n = 0;
    while (state_o != 3'd3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t2_stim_cycles", 32'(n),        32'd40);
    chk("t2_rt_ms",       32'(rt_ms),    32'd10);
    chk("t2_timeout",     32'(timeout),  32'd1);
    chk("t2_rt_valid",    32'(rt_valid), 32'd1);
    chk("t2_early",       32'(early),    32'd0);
    @(negedge clk);
    chk("t2_rt_valid_once", 32'(rt_valid), 32'd0);
    chk("t2_timeout_hold",  32'(timeout),  32'd1);

    // Trial 3: stop during WAIT -> EARLY; start ignored; clear returns to IDLE.
    pulse_clear();
    chk("clr2_timeout", 32'(timeout), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t3_state_early", 32'(state_o), 32'd4);
    chk("t3_early",       32'(early),   32'd1);
    chk("t3_rt_ms",       32'(rt_ms),   32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (stim_led || state_o != 3'd4 || ms_tick) bad++;
      @(negedge clk);
    end
    chk("t3_early_sticky", 32'(bad), 32'd0);
    pulse_clear();
    chk("t3_clr_state",   32'(state_o), 32'd0);
    chk("t3_clr_early",   32'(early),   32'd0);
    chk("t3_clr_timeout", 32'(timeout), 32'd0);
    chk("t3_clr_rt_ms",   32'(rt_ms),   32'd0);

    // Trial 4: stop coincident with the 6th tick -> tick dropped, rt_ms stays 5.
    start_trial("t4", n, t);
    chk("t4_wait_cycles", 32'(n), 32'(exp_delay * 4));
    wait_ticks(5);
    @(negedge clk);
    chk("t4_rt_5", 32'(rt_ms), 32'd5);
    wait_ticks(1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t4_rt_ms",    32'(rt_ms),    32'd5);
    chk("t4_state",    32'(state_o),  32'd3);
    chk("t4_rt_valid", 32'(rt_valid), 32'd1);

    // Trial 5: clear and stop together in STIM -> IDLE, no rt_valid.
    pulse_clear();
    start_trial("t5", n, t);
    chk("t5_wait_cycles", 32'(n), 32'(exp_delay * 4));
    wait_ticks(2);
    @(negedge clk);
    clear = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    stop  = 1'b0;
    chk("t5_state",    32'(state_o),  32'd0);
    chk("t5_rt_valid", 32'(rt_valid), 32'd0);
    chk("t5_rt_ms",    32'(rt_ms),    32'd0);
    @(negedge clk);
    chk("t5_rt_valid_later", 32'(rt_valid), 32'd0);

    // Trial 6: async reset mid-STIM, then LFSR restarts at ACE1 -> 16 cycles again.
    start_trial("t6", n, t);
    wait_ticks(3);
    @(negedge clk);
    chk("t6_rt_pre", 32'(rt_ms), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_stim",  32'(stim_led), 32'd0);
    chk("t6_async_rt_ms", 32'(rt_ms),    32'd0);
    chk("t6_async_state", 32'(state_o),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start_trial("t6b", n, t);
    chk("t6_restart_cycles", 32'(n), 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
